ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter BIT_THRESH, 30, high-pulse length in sys_clk cycles at or above which a bit decodes as 1 (0.6 us at 50 MHz).
REQ-002 Parameter MIN_HIGH, 5, shortest legal high pulse in cycles.
REQ-003 Parameter MAX_HIGH, 60, longest legal high pulse in cycles.
REQ-004 Parameter RESET_LOW, 2500, low time in cycles that marks a frame reset (50 us).
REQ-005 Parameter PIXEL_MAX, 64, pixels per frame (8x8 matrix).
REQ-006 sys_clk  input  1  system clock, 50 MHz.
REQ-007 sys_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-008 din  input  1  asynchronous WS2812 serial line (NRZ, GRB, MSB first).
REQ-009 pix_data  output  24  last decoded pixel, {G,R,B}.
REQ-010 pix_valid  output  1  one-cycle strobe when pix_data/pix_index are updated.
REQ-011 pix_index  output  7  index of the pixel in pix_data, 0-based within the frame.
REQ-012 frame_done  output  1  one-cycle strobe on a valid reset-low after at least one pixel.
REQ-013 pix_count  output  7  pixels received in the last completed frame; updated with frame_done.
REQ-014 err  output  1  one-cycle strobe on any protocol violation.

Function
REQ-015 din SHALL pass through a 2-flop synchronizer; all edge detection uses the synchronized value, so internal latency is 2 cycles plus 1 cycle for edge detection.
REQ-016 FSM states SHALL be: WAIT_RST, IDLE, HIGH, LOW.
REQ-017 WAIT_RST: count consecutive low cycles; at RESET_LOW go to IDLE; any high clears the count.
REQ-018 IDLE: on a rising edge, clear the high counter and go to HIGH.
REQ-019 HIGH: count cycles; on a falling edge with count in [MIN_HIGH, MAX_HIGH], shift bit (count >= BIT_THRESH) into a 24-bit shift register, increment bit_cnt and go to LOW.
REQ-020 HIGH: a count < MIN_HIGH at the falling edge, or count exceeding MAX_HIGH while still high, SHALL strobe err, discard the partial pixel and go to WAIT_RST.
REQ-021 On the 24th bit, the block SHALL register pix_data, drive pix_index equal to the current pixel counter, assert pix_valid for exactly 1 cycle on the cycle after the falling edge, clear bit_cnt and increment the pixel counter.
REQ-022 LOW: count low cycles; a rising edge before RESET_LOW returns to HIGH (next bit).
REQ-023 LOW reaching RESET_LOW with bit_cnt == 0 and pixel counter > 0: strobe frame_done, load pix_count, clear the pixel counter, go to IDLE.
REQ-024 LOW reaching RESET_LOW with bit_cnt != 0: strobe err, discard the partial pixel, load pix_count with the complete pixels, strobe frame_done only if pixel counter > 0, go to IDLE.
REQ-025 A pixel completing when the pixel counter == PIXEL_MAX SHALL strobe err without pix_valid; the counter saturates and the frame stays in progress.
REQ-026 All counters SHALL saturate, never wrap; the low/reset counter is 12 bits and the high counter is 7 bits.
REQ-027 err and frame_done in the same cycle are legal; pix_valid and frame_done never coincide.

Reset
REQ-028 On sys_rst_n low: state WAIT_RST, synchronizer flops 0, pix_data 0, pix_index 0, pix_count 0, pix_valid/frame_done/err 0, and all counters 0.
REQ-029 Reset mid-frame SHALL drop all partial data; after release, no pixel is decoded until RESET_LOW low cycles are seen.

Structure
REQ-030 The WS2812 timing constants (T0H, T1H, bit period, RESET_LOW) and PIXEL_MAX SHALL live in the shared ws2812 package/header used by the transmitter.
REQ-031 One sub-module is natural: ws2812_pulse_meas (synchronizer, edge detect, high/low counters); the FSM and pixel assembly stay in ws2812_rx.

Verification
REQ-032 Loopback from the existing WS2812 transmitter with 64 pixels 0x00FF00,0x010203,... plus reset -> 64 pix_valid, data matches in order, and frame_done with pix_count=64.
REQ-033 Single pixel 0xA5C35A (high pulses of 20 and 40 cycles) followed by 2500 low -> pix_valid with 0xA5C35A and index 0, frame_done with pix_count=1, and no err.
REQ-034 Twelve bits then 2500 low -> err, no pix_valid, and no frame_done.
REQ-035 Glitch high of 3 cycles, and separately din held high for 61 cycles -> err, then no decode until 2500 low cycles.
REQ-036 65 pixels then reset -> err on the 65th pixel, frame_done with pix_count=64.
REQ-037 Assert sys_rst_n after pixel 10 of a frame, release, then send a new frame -> outputs 0 during reset, and the new frame decodes from index 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing, frame limits and receiver types.
// All timing values are in 50 MHz system clock cycles.
package ws2812_pkg;

  localparam int unsigned T0H_CYC        = 20;    // 0.4 us high for a 0 bit
  localparam int unsigned T1H_CYC        = 40;    // 0.8 us high for a 1 bit
  localparam int unsigned BIT_PERIOD_CYC = 63;    // 1.25 us bit period
  localparam int unsigned RESET_LOW_CYC  = 2500;  // 50 us latch/reset low
  localparam int unsigned PIXEL_MAX_N    = 64;    // 8x8 matrix
  localparam int unsigned BIT_THRESH_CYC = 30;
  localparam int unsigned MIN_HIGH_CYC   = 5;
  localparam int unsigned MAX_HIGH_CYC   = 60;

  localparam int unsigned HighCntW = 7;
  localparam int unsigned LowCntW  = 12;
  localparam int unsigned PixCntW  = 7;
  localparam int unsigned BitCntW  = 5;

  typedef enum logic [1:0] {
    StWaitRst,
    StIdle,
    StHigh,
    StLow
  } rx_state_e;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Synchronises the WS2812 line and measures the length of the current
// high and low runs with saturating counters.
module ws2812_pulse_meas
  import ws2812_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                din_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [HighCntW-1:0] high_cnt_o,
  output logic [LowCntW-1:0]  low_cnt_o
);

  logic                sync1_q, sync2_q, prev_q;
  logic [HighCntW-1:0] hcnt_q, hcnt_d;
  logic [LowCntW-1:0]  lcnt_q, lcnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Each counter runs while its level persists and clears on the opposite
  // level, so at an edge it holds the full length of the run just ended.
  always_comb begin
    hcnt_d = '0;
    lcnt_d = '0;
    if (sync2_q) begin
      hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
    end else begin
      lcnt_d = (lcnt_q == '1) ? lcnt_q : lcnt_q + 1'b1;
    end
  end

  assign level_o    = sync2_q;
  assign rise_o     = sync2_q & ~prev_q;
  assign fall_o     = ~sync2_q & prev_q;
  assign high_cnt_o = hcnt_q;
  assign low_cnt_o  = lcnt_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes GRB pixels from the serial line, reports
// per-pixel strobes, end-of-frame pixel count and protocol errors.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned BIT_THRESH = BIT_THRESH_CYC,
  parameter int unsigned MIN_HIGH   = MIN_HIGH_CYC,
  parameter int unsigned MAX_HIGH   = MAX_HIGH_CYC,
  parameter int unsigned RESET_LOW  = RESET_LOW_CYC,
  parameter int unsigned PIXEL_MAX  = PIXEL_MAX_N
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        din,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic [6:0]  pix_index,
  output logic        frame_done,
  output logic [6:0]  pix_count,
  output logic        err
);

  localparam logic [HighCntW-1:0] BitThreshC  = HighCntW'(BIT_THRESH);
  localparam logic [HighCntW-1:0] MinHighC    = HighCntW'(MIN_HIGH);
  localparam logic [HighCntW-1:0] MaxHighC    = HighCntW'(MAX_HIGH);
  localparam logic [LowCntW-1:0]  ResetLowM1C = LowCntW'(RESET_LOW - 1);
  localparam logic [PixCntW-1:0]  PixMaxC     = PixCntW'(PIXEL_MAX);

  logic                level, rise, fall;
  logic [HighCntW-1:0] high_cnt;
  logic [LowCntW-1:0]  low_cnt;
  logic                low_done;

  rx_state_e          state_q, state_d;
  logic [23:0]        shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PixCntW-1:0] pix_cnt_q, pix_cnt_d;
  logic [23:0]        pix_data_q, pix_data_d;
  logic [6:0]         pix_index_q, pix_index_d;
  logic [6:0]         pix_count_q, pix_count_d;
  logic               pix_valid_q, pix_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;

  ws2812_pulse_meas u_pulse_meas (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .din_i      (din),
    .level_o    (level),
    .rise_o     (rise),
    .fall_o     (fall),
    .high_cnt_o (high_cnt),
    .low_cnt_o  (low_cnt)
  );

  // low_cnt lags the line by one cycle, so this fires on the RESET_LOW-th low cycle.
  assign low_done = ~level && (low_cnt >= ResetLowM1C);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StWaitRst;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      pix_data_q   <= '0;
      pix_index_q  <= '0;
      pix_count_q  <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_data_q   <= pix_data_d;
      pix_index_q  <= pix_index_d;
      pix_count_q  <= pix_count_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    pix_data_d   = pix_data_q;
    pix_index_d  = pix_index_q;
    pix_count_d  = pix_count_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      StWaitRst: begin
        if (low_done) state_d = StIdle;
      end
      StIdle: begin
        if (rise) state_d = StHigh;
      end
      StHigh: begin
        // A malformed pulse abandons the whole frame; resync on the next reset-low.
        if ((level && (high_cnt > MaxHighC)) ||
            (fall && ((high_cnt < MinHighC) || (high_cnt > MaxHighC)))) begin
          err_d     = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          pix_cnt_d = '0;
          state_d   = StWaitRst;
        end else if (fall) begin
          shift_d = {shift_q[22:0], (high_cnt >= BitThreshC)};
          state_d = StLow;
          if (bit_cnt_q == BitCntW'(23)) begin
            bit_cnt_d = '0;
            if (pix_cnt_q < PixMaxC) begin
              pix_data_d  = shift_d;
              pix_index_d = pix_cnt_q;
              pix_valid_d = 1'b1;
              pix_cnt_d   = pix_cnt_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
        end else if (low_done) begin
          err_d        = (bit_cnt_q != '0);
          frame_done_d = (pix_cnt_q != '0);
          pix_count_d  = pix_cnt_q;
          pix_cnt_d    = '0;
          bit_cnt_d    = '0;
          shift_d      = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StWaitRst;
    endcase
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_index  = pix_index_q;
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised bench for ws2812_rx: a protocol-level model queues expected
// pixels, frame ends and errors; a monitor checks every DUT strobe.
module tb_ws2812_rx;

  localparam int BitThresh = 30;
  localparam int MinHigh   = 5;
  localparam int MaxHigh   = 60;
  localparam int ResetLow  = 2500;
  localparam int PixelMax  = 64;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        din       = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic [6:0]  pix_index;
  logic        frame_done;
  logic [6:0]  pix_count;
  logic        err;

  int checks = 0;
  int passes = 0;

  logic [23:0] exp_data_q[$];
  int          exp_idx_q[$];
  int          exp_frame_q[$];
  int          exp_err = 0;

  bit          m_armed = 1'b0;
  int          m_bits  = 0;
  int          m_pix   = 0;
  logic [23:0] m_acc   = '0;

  always #10 sys_clk = ~sys_clk;

  ws2812_rx dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .din        (din),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .frame_done (frame_done),
    .pix_count  (pix_count),
    .err        (err)
  );

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  always @(negedge sys_clk) begin : monitor
    logic [23:0] ed;
    int          ei, ef;
    if (sys_rst_n) begin
      if (pix_valid) begin
        checks++;
        if (exp_data_q.size() == 0) begin
          $display("FAIL pix_valid: unexpected pixel %06h index %0d, required none",
                   pix_data, pix_index);
        end else begin
          ed = exp_data_q.pop_front();
          ei = exp_idx_q.pop_front();
          if (pix_data == ed && int'(pix_index) == ei) passes++;
          else $display("FAIL pixel: got %06h index %0d, required %06h index %0d",
                        pix_data, pix_index, ed, ei);
        end
      end
      if (frame_done) begin
        checks++;
        if (exp_frame_q.size() == 0) begin
          $display("FAIL frame_done: unexpected strobe pix_count %0d, required none", pix_count);
        end else begin
          ef = exp_frame_q.pop_front();
          if (int'(pix_count) == ef) passes++;
          else $display("FAIL frame pix_count: got %0d, required %0d", pix_count, ef);
        end
      end
      if (err) begin
        checks++;
        if (exp_err > 0) begin
          exp_err--;
          passes++;
        end else begin
          $display("FAIL err: got unexpected strobe, required none");
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Protocol model: one legal high pulse is one bit, 24 bits are one pixel.
  task automatic model_pulse(input int len);
    if (!m_armed) return;
    if (len < MinHigh || len > MaxHigh) begin
      exp_err++;
      m_armed = 1'b0;
      m_bits  = 0;
      m_pix   = 0;
      return;
    end
    m_acc = {m_acc[22:0], (len >= BitThresh)};
    m_bits++;
    if (m_bits == 24) begin
      m_bits = 0;
      if (m_pix < PixelMax) begin
        exp_data_q.push_back(m_acc);
        exp_idx_q.push_back(m_pix);
        m_pix++;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic model_reset_low();
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_bits != 0 || m_pix != 0) begin
      if (m_bits != 0) exp_err++;
      if (m_pix != 0) exp_frame_q.push_back(m_pix);
      m_bits = 0;
      m_pix  = 0;
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_pulse(input int len, input int gap);
    model_pulse(len);
    hold(1'b1, len);
    hold(1'b0, gap);
  endtask

  task automatic send_reset_low(input int extra);
    model_reset_low();
    hold(1'b0, ResetLow + extra);
  endtask

  function automatic int bit_len(input bit b, input bit fast);
    if (fast) return b ? int'($urandom_range(BitThresh, BitThresh + 2))
                       : int'($urandom_range(MinHigh, MinHigh + 2));
    if ($urandom_range(0, 3) == 0) begin
      if (b) return $urandom_range(0, 1) ? BitThresh : MaxHigh;
      return $urandom_range(0, 1) ? MinHigh : BitThresh - 1;
    end
    return b ? int'($urandom_range(BitThresh, MaxHigh))
             : int'($urandom_range(MinHigh, BitThresh - 1));
  endfunction

  task automatic send_pixel(input logic [23:0] d, input bit fast);
    for (int i = 23; i >= 0; i--) begin
      send_pulse(bit_len(d[i], fast), fast ? int'($urandom_range(2, 4))
                                           : int'($urandom_range(2, 20)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pix_data"},   32'(pix_data),   32'd0);
    check({tag, " pix_index"},  32'(pix_index),  32'd0);
    check({tag, " pix_count"},  32'(pix_count),  32'd0);
    check({tag, " pix_valid"},  32'(pix_valid),  32'd0);
    check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    check({tag, " err"},        32'(err),        32'd0);
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;

    // Pulses before the first reset-low must be ignored.
    send_pulse(40, 20);
    send_pulse(20, 20);
    send_reset_low(0);

    // Single known pixel with nominal 20/40 cycle pulses.
    for (int i = 23; i >= 0; i--) begin
      automatic logic [23:0] px = 24'hA5C35A;
      automatic int len = px[i] ? 40 : 20;
      send_pulse(len, 63 - len);
    end
    send_reset_low(0);

    // Full 64-pixel frame in the 0x00FF00, 0x010203, ... pattern.
    send_pixel(24'h00FF00, 1'b1);
    for (int i = 1; i < 64; i++) send_pixel({8'(i), 8'(i + 1), 8'(i + 2)}, 1'b1);
    send_reset_low(int'($urandom_range(0, 20)));

    // Short random frames with the full legal pulse range.
    for (int f = 0; f < 2; f++) begin
      automatic int n = int'($urandom_range(1, 3));
      for (int p = 0; p < n; p++) send_pixel(24'($urandom()), 1'b0);
      send_reset_low(int'($urandom_range(0, 20)));
    end

    // Twelve bits then reset-low: partial pixel error only.
    for (int i = 0; i < 12; i++) send_pulse(bit_len(1'($urandom()), 1'b0), 10);
    send_reset_low(5);

    // Glitch mid-frame, ignored bits, resync; then an over-long high from idle.
    send_pixel(24'($urandom()), 1'b1);
    send_pixel(24'($urandom()), 1'b1);
    send_pulse(3, 10);
    send_pixel(24'($urandom()), 1'b1);
    send_reset_low(0);
    send_pulse(61, 10);
    send_pulse(100, 10);
    send_pulse(20, 10);
    send_reset_low(3);
    send_pixel(24'($urandom()), 1'b0);
    send_reset_low(0);

    // 65 pixels: the last one overflows, frame still reports 64.
    for (int i = 0; i < 65; i++) send_pixel({16'h0, 8'(i)}, 1'b1);
    send_reset_low(0);

    // Reset after pixel 10, then a fresh frame starts at index 0.
    for (int i = 0; i < 10; i++) send_pixel(24'($urandom()), 1'b1);
    hold(1'b0, 20);
    sys_rst_n = 1'b0;
    m_armed = 1'b0;
    m_bits  = 0;
    m_pix   = 0;
    hold(1'b0, 3);
    check_reset_outputs("midframe reset");
    sys_rst_n = 1'b1;
    send_pixel(24'($urandom()), 1'b1);
    send_reset_low(0);
    for (int i = 0; i < 3; i++) send_pixel(24'($urandom()), 1'b1);
    send_reset_low(0);

    hold(1'b0, 50);
    check("pixels outstanding", 32'(exp_data_q.size()), 32'd0);
    check("frames outstanding", 32'(exp_frame_q.size()), 32'd0);
    check("errors outstanding", 32'(exp_err), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
